// File: rtl/ram_byte_ctrl.sv
// ram_byte_ctrl: serializes 32-bit word requests from the data cache onto a
// byte-wide synchronous RAM with a 1-cycle read latency. The word is little-endian.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_addr_i/we/sel/data/ce_i   word request (sampled only on acceptance)
//   req_data_o          assembled read word (held until the next read completes)
//   req_data_ready_o    one-cycle completion pulse
//   mem_a_o/wr_o/dout_o byte RAM address, write strobe, write byte
//   mem_din_i           byte RAM read data, valid one cycle after its address
module ram_byte_ctrl #(
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           req_addr_i,
  input  logic                  req_we_i,
  input  logic [3:0]            req_sel_i,
  input  logic [31:0]           req_data_i,
  input  logic                  req_ce_i,
  output logic [31:0]           req_data_o,
  output logic                  req_data_ready_o,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic                  mem_wr_o,
  output logic [7:0]            mem_dout_o,
  input  logic [7:0]            mem_din_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [23:0]           rbuf_q, rbuf_d;
  logic [31:0]           req_data_q, req_data_d;
  logic                  ready_q, ready_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [7:0]            mem_dout_q, mem_dout_d;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic [1:0]            next_byte;

  // Bits above the RAM address width are dropped by design; the low-bit sum
  // equals the 32-bit sum truncated.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:ADDR_WIDTH];

  assign next_addr = addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
  assign next_byte = 2'(cnt_q + 3'd1);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      req_data_q <= '0;
      ready_q    <= 1'b0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      req_data_q <= req_data_d;
      ready_q    <= ready_d;
      mem_a_q    <= mem_a_d;
      mem_wr_q   <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
    end
  end

  // Next-state and next-output logic; bus outputs idle at 0 unless driven
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    req_data_d = req_data_q;
    ready_d    = 1'b0;
    mem_a_d    = '0;
    mem_wr_d   = 1'b0;
    mem_dout_d = '0;

    case (state_q)
      S_IDLE: begin
        if (req_ce_i) begin
          addr_d  = ADDR_WIDTH'(req_addr_i);
          sel_d   = req_sel_i;
          wdata_d = req_data_i;
          cnt_d   = '0;
          mem_a_d = ADDR_WIDTH'(req_addr_i);
          if (req_we_i) begin
            state_d    = S_WRITE;
            mem_wr_d   = req_sel_i[0];
            mem_dout_d = req_data_i[7:0];
          end else begin
            state_d = S_READ;
          end
        end
      end

      // cnt_q = c in cycle T+1+c: address c is on the bus, byte c-1 is on mem_din_i
      S_READ: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q < 3'd3) begin
          mem_a_d = next_addr;
        end
        case (cnt_q)
          3'd1: rbuf_d[7:0]   = mem_din_i;
          3'd2: rbuf_d[15:8]  = mem_din_i;
          3'd3: rbuf_d[23:16] = mem_din_i;
          3'd4: begin
            req_data_d = {mem_din_i, rbuf_q};
            ready_d    = 1'b1;
            state_d    = S_DONE;
          end
          default: ;
        endcase
      end

      // cnt_q = c in cycle T+1+c: byte c is being written
      S_WRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd3) begin
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          mem_a_d    = next_addr;
          mem_wr_d   = sel_q[next_byte];
          mem_dout_d = wdata_q[{next_byte, 3'b000} +: 8];
        end
      end

      // Request inputs are ignored here so an unretired request is not re-issued
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_data_o       = req_data_q;
  assign req_data_ready_o = ready_q;
  assign mem_a_o          = mem_a_q;
  assign mem_wr_o         = mem_wr_q;
  assign mem_dout_o       = mem_dout_q;

endmodule
